// File: rtl/apb_arb_pkg.sv
// ----------------------------------------------------------------------------
// apb_arb_pkg
// Shared types and constants for the two-master APB arbiter.
//   arb_state_e : arbiter FSM state (idle / setup / access)
//   mst_idx_t   : master index (0 = m0, 1 = m1)
//   ERR_DATA    : read data returned on a watchdog-forced completion
// ----------------------------------------------------------------------------
package apb_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_SETUP  = 2'd1,
        ARB_ACCESS = 2'd2
    } arb_state_e;

    typedef logic mst_idx_t;

    localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/apb_rr_arbiter.sv
// ----------------------------------------------------------------------------
// apb_rr_arbiter
// Combinational 2-way round-robin grant. On a tie the master that was not
// served last wins; a single requester always wins.
// Ports:
//   req_i       in  [1:0]  pending requests (bit n = master n)
//   last_i      in  1      index of the master served most recently
//   gnt_valid_o out 1      at least one request is pending
//   gnt_idx_o   out 1      index of the granted master
// ----------------------------------------------------------------------------
module apb_rr_arbiter
    import apb_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  mst_idx_t   last_i,
    output logic       gnt_valid_o,
    output mst_idx_t   gnt_idx_o
);

    // Grant selection: single requester wins, tie goes to the non-last master
    always_comb begin
        gnt_valid_o = |req_i;
        case (req_i)
            2'b01:   gnt_idx_o = 1'b0;
            2'b10:   gnt_idx_o = 1'b1;
            2'b11:   gnt_idx_o = ~last_i;
            default: gnt_idx_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/apb_bus_arbiter.sv
// ----------------------------------------------------------------------------
// apb_bus_arbiter
// Shares one APB slave between two APB masters. A pending transfer (PSEL=1)
// is granted round-robin, captured, and replayed on the slave bus with its
// own setup and access phases; the slave response goes back only to the
// granted master. The other master sees PREADY=0 until it is served.
//
// Ports:
//   PCLK, PRESETn                   clock, async active-low reset
//   m0_* / m1_*                     APB slave ports facing the two masters
//   s_PSEL/PENABLE/PWRITE/PADDR/PWDATA  replayed transfer to the slave
//   s_PRDATA/PREADY/PSLVERR         slave response
//
// Optional feature (macro APB_ARB_TIMEOUT_EN): an access-phase watchdog that
// force-completes a transfer with PSLVERR=1 and PRDATA=ERR_DATA after
// TIMEOUT_CYCLES slave wait cycles. Without the macro the arbiter waits on
// s_PREADY indefinitely.
// ----------------------------------------------------------------------------
module apb_bus_arbiter
    import apb_arb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              m0_PSEL,
    input  logic              m0_PENABLE,
    input  logic              m0_PWRITE,
    input  logic [ADDR_W-1:0] m0_PADDR,
    input  logic [DATA_W-1:0] m0_PWDATA,
    output logic [DATA_W-1:0] m0_PRDATA,
    output logic              m0_PREADY,
    output logic              m0_PSLVERR,
    input  logic              m1_PSEL,
    input  logic              m1_PENABLE,
    input  logic              m1_PWRITE,
    input  logic [ADDR_W-1:0] m1_PADDR,
    input  logic [DATA_W-1:0] m1_PWDATA,
    output logic [DATA_W-1:0] m1_PRDATA,
    output logic              m1_PREADY,
    output logic              m1_PSLVERR,
    output logic              s_PSEL,
    output logic              s_PENABLE,
    output logic              s_PWRITE,
    output logic [ADDR_W-1:0] s_PADDR,
    output logic [DATA_W-1:0] s_PWDATA,
    input  logic [DATA_W-1:0] s_PRDATA,
    input  logic              s_PREADY,
    input  logic              s_PSLVERR
);

    arb_state_e        state_q, state_d;
    mst_idx_t          gnt_q, gnt_d;
    mst_idx_t          last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              write_q, write_d;

    logic              gnt_valid_s;
    mst_idx_t          gnt_idx_s;
    logic              tmo_hit_s;
    logic              done_s;
    logic              rsp_ready_s;
    logic              rsp_err_s;
    logic [DATA_W-1:0] rsp_data_s;
    logic              unused_s;

    // PENABLE is deliberately not part of the request: a stalled master may
    // already be holding it high while it waits for its grant.
    apb_rr_arbiter u_rr (
        .req_i       ({m1_PSEL, m0_PSEL}),
        .last_i      (last_q),
        .gnt_valid_o (gnt_valid_s),
        .gnt_idx_o   (gnt_idx_s)
    );

`ifdef APB_ARB_TIMEOUT_EN
    logic [7:0] tmo_cnt_q, tmo_cnt_d;

    assign tmo_hit_s = (state_q == ARB_ACCESS) && (tmo_cnt_q == 8'(TIMEOUT_CYCLES));
    assign unused_s  = ^{m0_PENABLE, m1_PENABLE};

    // Watchdog next value: clear when a transfer is granted, count slave wait cycles
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if ((state_q == ARB_IDLE) && gnt_valid_s) begin
            tmo_cnt_d = 8'd0;
        end else if ((state_q == ARB_ACCESS) && !s_PREADY && !tmo_hit_s) begin
            tmo_cnt_d = tmo_cnt_q + 8'd1;
        end else begin
            tmo_cnt_d = tmo_cnt_q;
        end
    end

    // Watchdog counter register
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tmo_cnt_q <= 8'd0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign tmo_hit_s = 1'b0;
    assign unused_s  = ^{m0_PENABLE, m1_PENABLE, (TIMEOUT_CYCLES != 32'sd0)};
`endif

    assign done_s = s_PREADY | tmo_hit_s;

    // FSM next state, grant/last pointers and transfer capture
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        case (state_q)
            ARB_IDLE: begin
                if (gnt_valid_s) begin
                    state_d = ARB_SETUP;
                    gnt_d   = gnt_idx_s;
                    addr_d  = gnt_idx_s ? m1_PADDR  : m0_PADDR;
                    wdata_d = gnt_idx_s ? m1_PWDATA : m0_PWDATA;
                    write_d = gnt_idx_s ? m1_PWRITE : m0_PWRITE;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_SETUP: begin
                state_d = ARB_ACCESS;
            end
            ARB_ACCESS: begin
                if (done_s) begin
                    state_d = ARB_IDLE;
                    last_d  = gnt_q;
                end else begin
                    state_d = ARB_ACCESS;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // FSM and capture registers; reset aborts any transfer without replay
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= ARB_IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
        end
    end

    // Slave-side drive from the capture registers; all zero while idle
    always_comb begin
        if (state_q != ARB_IDLE) begin
            s_PSEL   = 1'b1;
            s_PWRITE = write_q;
            s_PADDR  = addr_q;
            s_PWDATA = wdata_q;
        end else begin
            s_PSEL   = 1'b0;
            s_PWRITE = 1'b0;
            s_PADDR  = '0;
            s_PWDATA = '0;
        end
        s_PENABLE = (state_q == ARB_ACCESS);
    end

    // Response source: the slave, or a forced error when the watchdog fires
    // before the slave answers (a real slave response in that cycle wins)
    always_comb begin
        if (tmo_hit_s && !s_PREADY) begin
            rsp_ready_s = 1'b1;
            rsp_err_s   = 1'b1;
            rsp_data_s  = DATA_W'(ERR_DATA);
        end else begin
            rsp_ready_s = s_PREADY;
            rsp_err_s   = s_PSLVERR & s_PREADY;
            rsp_data_s  = s_PRDATA;
        end
    end

    // Route the response to the granted master only during the access phase
    always_comb begin
        m0_PREADY  = 1'b0;
        m0_PSLVERR = 1'b0;
        m0_PRDATA  = '0;
        m1_PREADY  = 1'b0;
        m1_PSLVERR = 1'b0;
        m1_PRDATA  = '0;
        if (state_q == ARB_ACCESS) begin
            if (gnt_q == 1'b0) begin
                m0_PREADY  = rsp_ready_s;
                m0_PSLVERR = rsp_err_s;
                m0_PRDATA  = rsp_data_s;
            end else begin
                m1_PREADY  = rsp_ready_s;
                m1_PSLVERR = rsp_err_s;
                m1_PRDATA  = rsp_data_s;
            end
        end else begin
            m0_PREADY = 1'b0;
            m1_PREADY = 1'b0;
        end
    end

endmodule

// File: tb/tb_apb_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_apb_bus_arbiter
// Directed bench for apb_bus_arbiter. Stimulus pushes the expected completion
// (master, address, direction, data, error) into a queue; a monitor pops and
// compares whenever a master sees PREADY=1. A small register-file slave with
// programmable wait states sits on the slave port.
// ----------------------------------------------------------------------------
module tb_apb_bus_arbiter;

    typedef struct {
        bit          idx;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        bit          err;
    } exp_t;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        psel   [2] = '{1'b0, 1'b0};
    logic        pen    [2] = '{1'b0, 1'b0};
    logic        pwr    [2] = '{1'b0, 1'b0};
    logic [31:0] paddr  [2] = '{32'h0, 32'h0};
    logic [31:0] pwdata [2] = '{32'h0, 32'h0};
    logic [31:0] prdata [2];
    logic        pready [2];
    logic        pslverr[2];

    logic        s_PSEL, s_PENABLE, s_PWRITE, s_PREADY, s_PSLVERR;
    logic [31:0] s_PADDR, s_PWDATA, s_PRDATA;

    logic [31:0] mem [16];
    bit          mem_ok = 1'b0;
    int          wcnt = 0;
    int          slv_wait = 0;
    bit          slv_hang = 1'b0;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    int          setup_cnt = 0;
    exp_t        sb[$];

    always #5 PCLK = ~PCLK;

    apb_bus_arbiter dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .m0_PSEL(psel[0]), .m0_PENABLE(pen[0]), .m0_PWRITE(pwr[0]),
        .m0_PADDR(paddr[0]), .m0_PWDATA(pwdata[0]),
        .m0_PRDATA(prdata[0]), .m0_PREADY(pready[0]), .m0_PSLVERR(pslverr[0]),
        .m1_PSEL(psel[1]), .m1_PENABLE(pen[1]), .m1_PWRITE(pwr[1]),
        .m1_PADDR(paddr[1]), .m1_PWDATA(pwdata[1]),
        .m1_PRDATA(prdata[1]), .m1_PREADY(pready[1]), .m1_PSLVERR(pslverr[1]),
        .s_PSEL(s_PSEL), .s_PENABLE(s_PENABLE), .s_PWRITE(s_PWRITE),
        .s_PADDR(s_PADDR), .s_PWDATA(s_PWDATA),
        .s_PRDATA(s_PRDATA), .s_PREADY(s_PREADY), .s_PSLVERR(s_PSLVERR)
    );

    // Slave model: 16-word register file, wait states, error at 0x3C
    assign s_PREADY  = s_PSEL && s_PENABLE && !slv_hang && (wcnt >= slv_wait);
    assign s_PRDATA  = mem[s_PADDR[5:2]];
    assign s_PSLVERR = (s_PADDR[5:0] == 6'h3C);

    always @(posedge PCLK) begin
        cyc <= cyc + 1;
        if (!mem_ok) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h1000_0000 + 32'(i);
            mem_ok <= 1'b1;
        end else begin
            if (s_PSEL && s_PENABLE && !s_PREADY) wcnt <= wcnt + 1;
            else wcnt <= 0;
            if (s_PSEL && s_PENABLE && s_PREADY && s_PWRITE) mem[s_PADDR[5:2]] <= s_PWDATA;
        end
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Monitor: pop and compare on every master-side completion
    always @(negedge PCLK) begin
        if (!PRESETn) begin
            setup_cnt = 0;
        end else begin
            exp_t e;
            int   idx;
            if (s_PSEL && !s_PENABLE) setup_cnt++;
            if (pready[0] && pready[1]) begin
                chk("both_ready", 32'd1, 32'd0);
            end else if (pready[0] || pready[1]) begin
                idx = pready[1] ? 1 : 0;
                if (sb.size() == 0) begin
                    chk("unexpected_ready", 32'(idx), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("grant_idx", 32'(idx), 32'(e.idx));
                    chk("s_paddr", s_PADDR, e.addr);
                    chk("s_pwrite", 32'(s_PWRITE), 32'(e.wr));
                    if (e.wr) chk("s_pwdata", s_PWDATA, e.data);
                    else      chk("prdata", prdata[idx], e.data);
                    chk("pslverr", 32'(pslverr[idx]), 32'(e.err));
                    chk("setup_cycles", 32'(setup_cnt), 32'd1);
                end
                setup_cnt = 0;
            end
        end
    end

    task automatic xfer(input int idx, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wd, output int lat);
        int c0;
        bit got;
        @(posedge PCLK); #1;
        psel[idx] = 1'b1; pen[idx] = 1'b0; pwr[idx] = wr;
        paddr[idx] = addr; pwdata[idx] = wd;
        c0 = cyc;
        lat = -1;
        @(posedge PCLK); #1;
        pen[idx] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge PCLK);
            if (pready[idx]) begin
                got = 1'b1;
                lat = cyc - c0;
            end
        end
        if (!got) chk("xfer_timeout", 32'd0, 32'd1);
        @(posedge PCLK); #1;
        psel[idx] = 1'b0; pen[idx] = 1'b0;
    endtask

    task automatic do_reset();
        PRESETn = 1'b0;
        repeat (2) @(posedge PCLK);
        #1 PRESETn = 1'b1;
    endtask

    initial begin
        int lat0, lat1, nsel, nwatch;
        bit seen;

        // Reset state
        repeat (3) @(negedge PCLK);
        chk("rst_s_psel", 32'(s_PSEL), 32'd0);
        chk("rst_s_penable", 32'(s_PENABLE), 32'd0);
        chk("rst_s_paddr", s_PADDR, 32'd0);
        chk("rst_s_pwdata", s_PWDATA, 32'd0);
        chk("rst_m0_pready", 32'(pready[0]), 32'd0);
        chk("rst_m1_pready", 32'(pready[1]), 32'd0);
        @(posedge PCLK); #1 PRESETn = 1'b1;

        // Single write then read by m0, zero-wait slave
        sb.push_back('{1'b0, 1'b1, 32'h04, 32'h1512_2024, 1'b0});
        xfer(0, 1'b1, 32'h04, 32'h1512_2024, lat0);
        sb.push_back('{1'b0, 1'b0, 32'h04, 32'h1512_2024, 1'b0});
        xfer(0, 1'b0, 32'h04, 32'h0, lat0);
        chk("read_latency", 32'(lat0), 32'd2);

        // Simultaneous requests right after reset: m0 first
        do_reset();
        sb.push_back('{1'b0, 1'b1, 32'h20, 32'h83, 1'b0});
        sb.push_back('{1'b1, 1'b0, 32'h00, 32'h1000_0000, 1'b0});
        fork
            xfer(0, 1'b1, 32'h20, 32'h83, lat0);
            xfer(1, 1'b0, 32'h00, 32'h0, lat1);
        join
        chk("simul_m0_latency", 32'(lat0), 32'd2);

        // Fairness: continuous requests from both, one wait state
        slv_wait = 1;
        for (int k = 0; k < 3; k++) begin
            sb.push_back('{1'b0, 1'b0, 32'(8 + 8 * k), 32'h1000_0002 + 32'(2 * k), 1'b0});
            sb.push_back('{1'b1, 1'b0, 32'(12 + 8 * k), 32'h1000_0003 + 32'(2 * k), 1'b0});
        end
        fork
            for (int k = 0; k < 3; k++) xfer(0, 1'b0, 32'(8 + 8 * k), 32'h0, lat0);
            for (int k = 0; k < 3; k++) xfer(1, 1'b0, 32'(12 + 8 * k), 32'h0, lat1);
        join

        // Stability: m1 changes its inputs while m0's transfer stalls
        slv_wait = 3;
        sb.push_back('{1'b0, 1'b1, 32'h28, 32'hA5A5_0001, 1'b0});
        sb.push_back('{1'b1, 1'b1, 32'h34, 32'h0BAD_F00D, 1'b0});
        nsel = 0;
        fork
            xfer(0, 1'b1, 32'h28, 32'hA5A5_0001, lat0);
            begin
                @(posedge PCLK); #1;
                psel[1] = 1'b1; pen[1] = 1'b0; pwr[1] = 1'b1;
                paddr[1] = 32'h00; pwdata[1] = 32'h1111_1111;
                for (int k = 1; k < 4; k++) begin
                    @(posedge PCLK); #1;
                    pen[1] = 1'b1;
                    paddr[1] = 32'(8 * k);
                    pwdata[1] = 32'(k) * 32'h0101_0101;
                end
                paddr[1] = 32'h34; pwdata[1] = 32'h0BAD_F00D;
                seen = 1'b0;
                for (int i = 0; i < 100 && !seen; i++) begin
                    @(negedge PCLK);
                    seen = pready[1];
                end
                if (!seen) chk("m1_stall_timeout", 32'd0, 32'd1);
                @(posedge PCLK); #1;
                psel[1] = 1'b0; pen[1] = 1'b0;
            end
            begin
                @(posedge PCLK);
                for (int k = 0; k < 6; k++) begin
                    @(negedge PCLK);
                    if (s_PSEL) begin
                        nsel++;
                        chk("stable_paddr", s_PADDR, 32'h28);
                        chk("stable_pwdata", s_PWDATA, 32'hA5A5_0001);
                    end
                end
            end
        join
        chk("m0_select_cycles", 32'(nsel), 32'd5);

        // Read back m1's settled write, then a slave error
        slv_wait = 0;
        sb.push_back('{1'b0, 1'b0, 32'h34, 32'h0BAD_F00D, 1'b0});
        xfer(0, 1'b0, 32'h34, 32'h0, lat0);
        sb.push_back('{1'b1, 1'b0, 32'h3C, 32'h1000_000F, 1'b1});
        xfer(1, 1'b0, 32'h3C, 32'h0, lat1);

        // Reset in the middle of a stalled access; no replay afterwards
        slv_hang = 1'b1;
        @(posedge PCLK); #1;
        psel[0] = 1'b1; pwr[0] = 1'b0; paddr[0] = 32'h08; pen[0] = 1'b0;
        @(posedge PCLK); #1 pen[0] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge PCLK);
            seen = s_PENABLE;
        end
        chk("reached_access", 32'(seen), 32'd1);
        @(negedge PCLK); #2;
        PRESETn = 1'b0;
        #1;
        chk("midrst_s_psel", 32'(s_PSEL), 32'd0);
        chk("midrst_s_penable", 32'(s_PENABLE), 32'd0);
        chk("midrst_s_paddr", s_PADDR, 32'd0);
        chk("midrst_m0_pready", 32'(pready[0]), 32'd0);
        psel[0] = 1'b0; pen[0] = 1'b0;
        repeat (2) @(posedge PCLK);
        #1 PRESETn = 1'b1;
        slv_hang = 1'b0;
        nwatch = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge PCLK);
            if (s_PSEL) nwatch++;
        end
        chk("no_replay", 32'(nwatch), 32'd0);
        sb.push_back('{1'b1, 1'b0, 32'h28, 32'hA5A5_0001, 1'b0});
        xfer(1, 1'b0, 32'h28, 32'h0, lat1);
        chk("post_reset_latency", 32'(lat1), 32'd2);

`ifdef APB_ARB_TIMEOUT_EN
        // Watchdog: slave never answers, forced error after 16 wait cycles
        slv_hang = 1'b1;
        sb.push_back('{1'b0, 1'b0, 32'h08, 32'hDEAD_BEEF, 1'b1});
        xfer(0, 1'b0, 32'h08, 32'h0, lat0);
        chk("timeout_latency", 32'(lat0), 32'd18);
        slv_hang = 1'b0;
        sb.push_back('{1'b1, 1'b0, 32'h20, 32'h83, 1'b0});
        xfer(1, 1'b0, 32'h20, 32'h0, lat1);
`endif

        // Drain the scoreboard
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge PCLK);
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
